rr_slice_arbiter: RTL and testbench
===================================

Name: rr_slice_arbiter

Overview:
- N-to-1 round-robin arbiter in front of a single registered forward slice (16-bit valid/ready stream stage).
- Shares one downstream stream channel among N_REQ upstream requesters.
- The winning beat is captured in an output register with full-throughput backpressure.
- Sits between the per-source producers and the shared consumer. Reports the source index of each beat.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- DW, 16, data width per beat.
- SW, $clog2(N_REQ), width of the source index (derived; not to be overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_vld  in  N_REQ  per-requester valid
- req_rdy  out  N_REQ  per-requester ready; one-hot or zero
- req_data  in  N_REQ*DW  requester i data on bits [i*DW +: DW]
- out_vld  out  1  output valid (registered)
- out_rdy  in  1  downstream ready
- out_data  out  DW  output data (registered)
- out_src  out  SW  index of the requester that supplied out_data (registered)

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_vld=0, out_data=0, out_src=0.
  - Round-robin pointer ptr=0; ptr means requester 0 has highest priority.
  - req_rdy=0 while in reset.
- Slot free:
  - slot_free = ~out_vld | out_rdy.
  - Gives full throughput: one beat per cycle when out_rdy stays high.
- Grant (combinational):
  - Scan req_vld starting at index ptr, wrapping modulo N_REQ.
  - The first set bit is gnt_idx; gnt_any = |req_vld.
- Ready:
  - req_rdy[i] = slot_free & gnt_any & (i==gnt_idx).
  - req_rdy has no combinational path from req_data.
  - req_rdy depends on req_vld and out_rdy.
- Accept:
  - acc = gnt_any & slot_free.
  - On acc at a clock edge: out_data<=req_data[gnt_idx], out_src<=gnt_idx, out_vld<=1, ptr<=(gnt_idx+1) mod N_REQ.
  - When gnt_idx=N_REQ-1, ptr wraps to 0.
- Drain: if not acc and out_rdy=1, out_vld<=0. Otherwise out_vld holds.
- Latency: one cycle from accepted request beat to out_vld.
- Stall behaviour:
  - While out_vld=1 and out_rdy=0: out_data and out_src are held stable, ptr is frozen, and all req_rdy=0.
  - A requester may change req_vld during a stall. Arbitration is re-evaluated each cycle; there is no grant memory between beats.
- Simultaneous events: when a pop (out_rdy) and a push (acc) happen in the same cycle, the new beat is loaded and out_vld stays 1.
- Only one requester: it is granted every cycle it is valid and the slot is free. ptr still advances past it.
- No requester valid: ptr unchanged, and the output drains normally.
- Fairness: with all N_REQ requesters continuously valid and out_rdy=1, grants cycle 0,1,...,N_REQ-1,0,... with one beat per cycle.

Optional Feature:
- Macro RR_SLICE_PKT_LOCK_EN.
- When defined:
  - Adds input port req_last, width N_REQ, qualifying each beat.
  - On acc of a beat with req_last[gnt_idx]=0, a lock is set to gnt_idx.
  - While locked, grant is forced to the locked index. Other requesters see req_rdy=0 even if the locked requester drops req_vld.
  - The lock clears on acceptance of the locked requester's beat with req_last=1.
  - ptr updates only on that last beat.
  - Adds output out_last, width 1, registered with out_data; it resets to 0.
  - Lock state resets to unlocked.
- When undefined: no req_last or out_last ports, and arbitration is per beat as described above.

Test Plan:
1. Reset mid-transfer: out_vld=1 holding 0x1234 when rst_n pulses low -> out_vld=0, out_data=0, out_src=0 immediately; after release, req_vld=4'b0100 gives out_src=2 one cycle later.
2. All four requesters valid, data 0xA000+i, out_rdy=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; out_vld continuously 1; out_data matches the source.
3. Backpressure: out_rdy=0 for 3 cycles with req_vld=4'b1111 -> out_data/out_src stable and req_rdy=0 throughout; when out_rdy=1, the next grant goes to (held out_src+1) mod 4.
4. Sparse requests: req_vld=4'b1001 with ptr=1 -> grant 3 then 0 then 3; requesters 1 and 2 are never granted.
5. Drain: single beat 0x00FF from requester 1, then req_vld=0 and out_rdy=1 -> out_vld=1 for exactly one cycle, then 0; ptr=2.
6. (RR_SLICE_PKT_LOCK_EN) Requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is continuously valid -> out_src=0,0,0 then 1; out_last=1 on the third beat only.

Source files
------------

// File: rtl/rr_slice_arbiter.sv
// rr_slice_arbiter: N_REQ-to-1 round-robin arbiter feeding a registered valid/ready forward slice.
// Define RR_SLICE_PKT_LOCK_EN to hold the grant on one requester until its req_last beat.
module rr_slice_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int SW    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_vld,
  output logic [N_REQ-1:0]    req_rdy,
  input  logic [N_REQ*DW-1:0] req_data,
`ifdef RR_SLICE_PKT_LOCK_EN
  input  logic [N_REQ-1:0]    req_last,
  output logic                out_last,
`endif
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [DW-1:0]       out_data,
  output logic [SW-1:0]       out_src
);

  logic [SW-1:0] ptr_r;
  logic          out_vld_r;
  logic [DW-1:0] out_data_r;
  logic [SW-1:0] out_src_r;

  logic [SW-1:0] rr_idx_s;
  logic          rr_any_s;
  logic [SW-1:0] scan_idx_s;
  logic [SW-1:0] gnt_idx_s;
  logic          gnt_any_s;
  logic          slot_free_s;
  logic          acc_s;
  logic          ptr_upd_s;
  logic [SW-1:0] ptr_nxt_s;

`ifdef RR_SLICE_PKT_LOCK_EN
  logic          lock_vld_r;
  logic [SW-1:0] lock_idx_r;
  logic          out_last_r;
`endif

  // Round-robin scan from ptr; walking offsets downwards lets the nearest valid index win.
  always_comb begin
    rr_idx_s   = {SW{1'b0}};
    rr_any_s   = 1'b0;
    scan_idx_s = {SW{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx_s = SW'((int'(ptr_r) + k) % N_REQ);
      rr_idx_s   = req_vld[scan_idx_s] ? scan_idx_s : rr_idx_s;
      rr_any_s   = req_vld[scan_idx_s] | rr_any_s;
    end
  end

  // Final grant: a held packet lock overrides the round-robin choice.
  always_comb begin
`ifdef RR_SLICE_PKT_LOCK_EN
    gnt_idx_s = lock_vld_r ? lock_idx_r : rr_idx_s;
    gnt_any_s = lock_vld_r ? req_vld[lock_idx_r] : rr_any_s;
    ptr_upd_s = acc_s & req_last[gnt_idx_s];
`else
    gnt_idx_s = rr_idx_s;
    gnt_any_s = rr_any_s;
    ptr_upd_s = acc_s;
`endif
  end

  assign slot_free_s = ~out_vld_r | out_rdy;
  assign acc_s       = gnt_any_s & slot_free_s;
  assign ptr_nxt_s   = (gnt_idx_s == SW'(N_REQ - 1)) ? {SW{1'b0}} : gnt_idx_s + SW'(1'b1);

  // One-hot ready toward the winner only; forced low while reset is asserted.
  always_comb begin
    req_rdy = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      req_rdy[i] = rst_n & acc_s & (gnt_idx_s == SW'(i));
    end
  end

  // Output slice and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_r  <= 1'b0;
      out_data_r <= {DW{1'b0}};
      out_src_r  <= {SW{1'b0}};
      ptr_r      <= {SW{1'b0}};
    end else begin
      if (acc_s) begin
        out_vld_r  <= 1'b1;
        out_data_r <= req_data[gnt_idx_s*DW +: DW];
        out_src_r  <= gnt_idx_s;
      end else if (out_rdy) begin
        out_vld_r  <= 1'b0;
      end else begin
        out_vld_r  <= out_vld_r;
      end
      if (ptr_upd_s) begin
        ptr_r <= ptr_nxt_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

`ifdef RR_SLICE_PKT_LOCK_EN
  // Packet lock: set on a non-last accepted beat, released by the same requester's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_r <= 1'b0;
      lock_idx_r <= {SW{1'b0}};
      out_last_r <= 1'b0;
    end else if (acc_s) begin
      lock_vld_r <= ~req_last[gnt_idx_s];
      lock_idx_r <= gnt_idx_s;
      out_last_r <= req_last[gnt_idx_s];
    end else begin
      lock_vld_r <= lock_vld_r;
      lock_idx_r <= lock_idx_r;
      out_last_r <= out_last_r;
    end
  end

  assign out_last = out_last_r;
`endif

  assign out_vld  = out_vld_r;
  assign out_data = out_data_r;
  assign out_src  = out_src_r;

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// Self-checking bench for rr_slice_arbiter: directed vector tables, reset/lock sequences,
// and randomized traffic against a behavioural round-robin model.
`timescale 1ns/1ps
module tb_rr_slice_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
`ifdef RR_SLICE_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_vld;
  logic [N-1:0]  req_rdy;
  logic [N*DW-1:0] req_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
`ifdef RR_SLICE_PKT_LOCK_EN
  logic [N-1:0]  req_last;
  logic          out_last;
`endif

  rr_slice_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_data (req_data),
`ifdef RR_SLICE_PKT_LOCK_EN
    .req_last (req_last),
    .out_last (out_last),
`endif
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_src  (out_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [3:0] vld, input logic ordy, input logic [63:0] data,
                       input logic [3:0] last);
    req_vld  = vld;
    out_rdy  = ordy;
    req_data = data;
`ifdef RR_SLICE_PKT_LOCK_EN
    req_last = last;
`else
    if (last != 4'b0000) begin end
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(4'b0000, 1'b0, 64'h0, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Behavioural model: pointer as an integer, grant found by walking indices from it.
  int       m_ptr;
  int       m_src;
  int       m_lock;
  bit       m_vld;
  logic [15:0] m_data;
`ifdef RR_SLICE_PKT_LOCK_EN
  bit       m_last;
`endif

  task automatic model_reset();
    m_ptr = 0; m_src = 0; m_lock = -1; m_vld = 1'b0; m_data = 16'h0000;
`ifdef RR_SLICE_PKT_LOCK_EN
    m_last = 1'b0;
`endif
  endtask

  task automatic cycle(input logic [3:0] vld, input logic ordy, input logic [63:0] data,
                       input logic [3:0] last);
    int g;
    bit any;
    bit fr;
    logic [3:0] er;
    apply(vld, ordy, data, last);
    #1;
    g = 0;
    any = 1'b0;
    if (m_lock >= 0) begin
      g = m_lock;
      any = vld[2'(g)];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!any && vld[2'((m_ptr + k) % N)]) begin
          g = (m_ptr + k) % N;
          any = 1'b1;
        end
      end
    end
    fr = !m_vld || ordy;
    er = (fr && any) ? 4'(1 << g) : 4'b0000;
    chk("rnd_rdy", req_rdy, er);
    @(posedge clk);
    if (fr && any) begin
      m_vld  = 1'b1;
      m_data = data[g*16 +: 16];
      m_src  = g;
`ifdef RR_SLICE_PKT_LOCK_EN
      m_last = last[2'(g)];
`endif
      if (LOCK_EN && !last[2'(g)]) begin
        m_lock = g;
      end else begin
        m_lock = -1;
        m_ptr  = (g + 1) % N;
      end
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    #1;
    chk("rnd_vld", out_vld, m_vld);
    chk("rnd_data", out_data, m_data);
    chk("rnd_src", out_src, m_src);
`ifdef RR_SLICE_PKT_LOCK_EN
    chk("rnd_last", out_last, m_last);
`endif
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic        ordy;
    logic [63:0] data;
    logic [3:0]  last;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [15:0] e_data;
    logic [1:0]  e_src;
    logic        e_last;
  } vec_t;

  localparam logic [63:0] DA = 64'hA003_A002_A001_A000;
  localparam logic [63:0] DF = 64'hA003_A002_00FF_A000;
  localparam logic [63:0] DB = 64'hB003_B002_B001_B000;

  vec_t tbl[19];
  vec_t ltb[5];

  initial begin
    // Fairness, backpressure, sparse requests, drain; starts from reset (ptr=0, slot empty).
    tbl[0]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b0010, 1'b1, 16'hA001, 2'd1, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b0100, 1'b1, 16'hA002, 2'd2, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b0010, 1'b1, 16'hA001, 2'd1, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b0100, 1'b1, 16'hA002, 2'd2, 1'b1};
    tbl[7]  = '{4'b1111, 1'b1, DA, 4'hF, 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[8]  = '{4'b1111, 1'b0, DA, 4'hF, 4'b0000, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[9]  = '{4'b1111, 1'b0, DA, 4'hF, 4'b0000, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[10] = '{4'b1111, 1'b0, DA, 4'hF, 4'b0000, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[11] = '{4'b1111, 1'b1, DA, 4'hF, 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b1};
    tbl[12] = '{4'b1001, 1'b1, DA, 4'hF, 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[13] = '{4'b1001, 1'b1, DA, 4'hF, 4'b0001, 1'b1, 16'hA000, 2'd0, 1'b1};
    tbl[14] = '{4'b1001, 1'b1, DA, 4'hF, 4'b1000, 1'b1, 16'hA003, 2'd3, 1'b1};
    tbl[15] = '{4'b0010, 1'b1, DF, 4'hF, 4'b0010, 1'b1, 16'h00FF, 2'd1, 1'b1};
    tbl[16] = '{4'b0000, 1'b1, DF, 4'hF, 4'b0000, 1'b0, 16'h00FF, 2'd1, 1'b1};
    tbl[17] = '{4'b0000, 1'b1, DF, 4'hF, 4'b0000, 1'b0, 16'h00FF, 2'd1, 1'b1};
    tbl[18] = '{4'b1111, 1'b1, DA, 4'hF, 4'b0100, 1'b1, 16'hA002, 2'd2, 1'b1};

    // Packet lock: 3-beat packet from 0 (with a drop mid-packet) while 1 stays valid.
    ltb[0] = '{4'b0011, 1'b1, DB, 4'b0000, 4'b0001, 1'b1, 16'hB000, 2'd0, 1'b0};
    ltb[1] = '{4'b0010, 1'b1, DB, 4'b0000, 4'b0000, 1'b0, 16'hB000, 2'd0, 1'b0};
    ltb[2] = '{4'b0011, 1'b1, DB, 4'b0000, 4'b0001, 1'b1, 16'hB000, 2'd0, 1'b0};
    ltb[3] = '{4'b0011, 1'b1, DB, 4'b0001, 4'b0001, 1'b1, 16'hB000, 2'd0, 1'b1};
    ltb[4] = '{4'b0011, 1'b1, DB, 4'b0000, 4'b0010, 1'b1, 16'hB001, 2'd1, 1'b0};

    // Reset values, then reset asserted while a beat is held.
    do_reset();
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_src", out_src, 2'd0);
    apply(4'b0001, 1'b0, 64'h0000_0000_0000_1234, 4'hF);
    @(posedge clk); #1;
    chk("hold_vld", out_vld, 1'b1);
    chk("hold_data", out_data, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", out_vld, 1'b0);
    chk("midrst_data", out_data, 16'h0000);
    chk("midrst_src", out_src, 2'd0);
    chk("midrst_rdy", req_rdy, 4'b0000);
    @(posedge clk); #1;
    chk("inrst_rdy", req_rdy, 4'b0000);
    rst_n = 1'b1;
    apply(4'b0100, 1'b1, 64'h0000_5555_0000_0000, 4'hF);
    #1;
    chk("postrst_rdy", req_rdy, 4'b0100);
    @(posedge clk); #1;
    chk("postrst_vld", out_vld, 1'b1);
    chk("postrst_src", out_src, 2'd2);
    chk("postrst_data", out_data, 16'h5555);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].vld, tbl[i].ordy, tbl[i].data, tbl[i].last);
      #1;
      chk($sformatf("tbl%0d_rdy", i), req_rdy, tbl[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_vld", i), out_vld, tbl[i].e_vld);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_src", i), out_src, tbl[i].e_src);
    end

`ifdef RR_SLICE_PKT_LOCK_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(ltb[i].vld, ltb[i].ordy, ltb[i].data, ltb[i].last);
      #1;
      chk($sformatf("lock%0d_rdy", i), req_rdy, ltb[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("lock%0d_vld", i), out_vld, ltb[i].e_vld);
      chk($sformatf("lock%0d_data", i), out_data, ltb[i].e_data);
      chk($sformatf("lock%0d_src", i), out_src, ltb[i].e_src);
      chk($sformatf("lock%0d_last", i), out_last, ltb[i].e_last);
    end
`endif

    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
